// File: rtl/alarm_controller.sv
// alarm_controller: anti-theft main FSM sequencing arm, entry delay, siren and disarm,
// with a two-step countdown load through the external time-parameter block.
module alarm_controller #(
   parameter int TW = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          one_hz_en,
   input  logic          ignition,
   input  logic          driver_door,
   input  logic          passenger_door,
   input  logic          reprogram,
   input  logic [TW-1:0] param_value,
   output logic [1:0]    interval,
   output logic          siren,
   output logic          status_led,
   output logic [2:0]    state,
   output logic [TW-1:0] count
);
   typedef enum logic [2:0] {
      ARMED      = 3'd0,
      TRIGGERED  = 3'd1,
      ALARM      = 3'd2,
      DISARMED   = 3'd3,
      WAIT_OPEN  = 3'd4,
      WAIT_CLOSE = 3'd5,
      ARM_DELAY  = 3'd6
   } state_t;
   state_t        st;
   logic          load_pending;
   logic          door;
   logic          timed;
   logic          expired;
   logic [TW-1:0] tick;
   assign door    = driver_door | passenger_door;
   assign timed   = (st == TRIGGERED) || (st == ALARM) || (st == ARM_DELAY);
   assign expired = timed && !load_pending && (count == '0);
   // param_value only reflects interval one cycle after it is registered, hence the pending load
   assign tick    = load_pending ? param_value : count - TW'(one_hz_en && (count != '0));
   assign siren   = (st == ALARM);
   assign state   = st;
   always_ff @(posedge clock) begin
      if (reset) begin
         st           <= ARMED;
         interval     <= 2'b00;
         count        <= '0;
         load_pending <= 1'b0;
         status_led   <= 1'b0;
      end else begin
         count        <= tick;
         load_pending <= 1'b0;
         status_led   <= 1'b0;
         if (reprogram) begin
            st    <= ARMED;
            count <= '0;
         end else if (ignition && st != DISARMED) begin
            st <= DISARMED;
         end else begin
            case (st)
               ARMED: begin
                  if (door) begin
                     st           <= TRIGGERED;
                     interval     <= driver_door ? 2'b01 : 2'b10;
                     load_pending <= 1'b1;
                     status_led   <= 1'b1;
                  end else begin
                     status_led <= status_led ^ one_hz_en;
                  end
               end
               TRIGGERED: begin
                  status_led <= 1'b1;
                  if (expired) begin
                     st           <= ALARM;
                     interval     <= 2'b11;
                     load_pending <= 1'b1;
                  end
               end
               ALARM: begin
                  // an open door keeps the alarm timer reloading until the car is closed
                  if (door) begin
                     load_pending <= 1'b1;
                     status_led   <= 1'b1;
                  end else if (expired) begin
                     st <= ARMED;
                  end else begin
                     status_led <= 1'b1;
                  end
               end
               DISARMED:   if (!ignition) st <= WAIT_OPEN;
               WAIT_OPEN:  if (driver_door) st <= WAIT_CLOSE;
               WAIT_CLOSE: begin
                  if (!driver_door) begin
                     st           <= ARM_DELAY;
                     interval     <= 2'b00;
                     load_pending <= 1'b1;
                  end
               end
               ARM_DELAY: begin
                  if (door) st <= WAIT_CLOSE;
                  else if (expired) st <= ARMED;
               end
               default: st <= ARMED;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed test-plan sequence plus random traffic checked against
// a transition-table reference model of the alarm controller.
module tb_alarm_controller;
   logic       clock = 1'b0;
   logic       reset, one_hz_en, ignition, driver_door, passenger_door, reprogram;
   logic [3:0] param_value, count;
   logic [1:0] interval;
   logic       siren, status_led;
   logic [2:0] state;
   logic [3:0] prm [4];
   int         n_asrt = 0;
   int         n_fail = 0;
   int         m_state, m_int, m_count;
   bit         m_load, m_led;

   always #5 clock = ~clock;
   assign param_value = prm[interval];

   alarm_controller #(.TW(4)) dut (
      .clock(clock), .reset(reset), .one_hz_en(one_hz_en), .ignition(ignition),
      .driver_door(driver_door), .passenger_door(passenger_door), .reprogram(reprogram),
      .param_value(param_value), .interval(interval), .siren(siren),
      .status_led(status_led), .state(state), .count(count)
   );

   function automatic bit timed(int s);
      return s == 1 || s == 2 || s == 6;
   endfunction

   function automatic void model_reset();
      m_state = 0; m_int = 0; m_count = 0; m_load = 0; m_led = 0;
   endfunction

   // decide the target state from the rules, then apply entry actions for the target
   function automatic void model_step();
      bit door = driver_door | passenger_door;
      bit expd = timed(m_state) && !m_load && m_count == 0;
      int nc   = m_load ? int'(prm[m_int]) : m_count - int'(one_hz_en && m_count > 0);
      bit nl   = 0;
      int tgt  = m_state;
      if (reprogram) begin tgt = 0; nc = 0; end
      else if (ignition && m_state != 3) tgt = 3;
      else if (m_state == 0 && door) tgt = 1;
      else if (m_state == 1 && expd) tgt = 2;
      else if (m_state == 2 && door) nl = 1;
      else if (m_state == 2 && expd) tgt = 0;
      else if (m_state == 3 && !ignition) tgt = 4;
      else if (m_state == 4 && driver_door) tgt = 5;
      else if (m_state == 5 && !driver_door) tgt = 6;
      else if (m_state == 6 && door) tgt = 5;
      else if (m_state == 6 && expd) tgt = 0;
      if (tgt != m_state && timed(tgt)) begin
         nl = 1;
         m_int = (tgt == 1) ? (driver_door ? 1 : 2) : (tgt == 2) ? 3 : 0;
      end
      m_led = (tgt == 1 || tgt == 2) ? 1'b1 :
              (tgt == 0 && m_state == 0 && !reprogram) ? m_led ^ one_hz_en : 1'b0;
      m_state = tgt; m_count = nc; m_load = nl;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      if (reset) model_reset(); else model_step();
      #1;
      chk("state", state, m_state);
      chk("siren", siren, m_state == 2);
      chk("interval", interval, m_int);
      chk("status_led", status_led, m_led);
      if (timed(m_state)) chk("count", count, m_count);
   endtask

   task automatic pulses(input int n);
      repeat (n) begin
         one_hz_en = 1; step();
         one_hz_en = 0; step();
      end
   endtask

   task automatic enter_alarm();
      driver_door = 1; step();
      driver_door = 0; step();
      pulses(8);
      step();
   endtask

   initial begin
      {one_hz_en, ignition, driver_door, passenger_door, reprogram} = '0;
      prm[0] = 6; prm[1] = 8; prm[2] = 15; prm[3] = 10;
      reset = 1; step(); step();
      reset = 0;
      chk("rst_state", state, 0);
      chk("rst_interval", interval, 0);
      chk("rst_siren", siren, 0);
      chk("rst_led", status_led, 0);
      pulses(3);
      chk("armed_blink", status_led, 1);
      // driver entry delay then alarm
      driver_door = 1; step();
      chk("drv_trig", state, 1);
      chk("drv_interval", interval, 1);
      driver_door = 0; step();
      chk("drv_count", count, 8);
      pulses(8);
      chk("drv_alarm", state, 2);
      chk("drv_siren", siren, 1);
      chk("drv_alarm_int", interval, 3);
      step(); pulses(10);
      chk("alarm_done", state, 0);
      // passenger entry, door held open through alarm
      passenger_door = 1; step();
      chk("pas_interval", interval, 2);
      step(); pulses(15);
      chk("pas_alarm", state, 2);
      pulses(20);
      chk("alarm_hold", count, 10);
      passenger_door = 0; step(); pulses(10);
      chk("pas_rearm", state, 0);
      chk("pas_siren_off", siren, 0);
      // ignition aborts entry delay, then exit-delay with a reopened door
      driver_door = 1; step();
      driver_door = 0; step();
      pulses(5);
      chk("ign_count", count, 3);
      ignition = 1; step();
      chk("ign_disarm", state, 3);
      chk("ign_siren", siren, 0);
      ignition = 0; step();
      driver_door = 1; step();
      driver_door = 0; step(); step();
      chk("armdly_count", count, 6);
      pulses(4);
      chk("armdly_mid", count, 2);
      driver_door = 1; step();
      chk("armdly_reopen", state, 5);
      driver_door = 0; step(); step();
      chk("armdly_reload", count, 6);
      pulses(6);
      chk("armdly_done", state, 0);
      // reprogram during alarm, then zero-length arm delay
      enter_alarm();
      pulses(2);
      reprogram = 1; step();
      reprogram = 0;
      chk("rp_state", state, 0);
      chk("rp_siren", siren, 0);
      chk("rp_count", count, 0);
      prm[0] = 0;
      ignition = 1; step();
      ignition = 0; step();
      driver_door = 1; step();
      driver_door = 0; step(); step();
      chk("zero_delay_load", state, 6);
      step();
      chk("zero_delay_done", state, 0);
      prm[0] = 6;
      // reset mid-countdown in alarm
      enter_alarm();
      pulses(5);
      chk("alarm_count5", count, 5);
      reset = 1; step();
      reset = 0;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_siren", siren, 0);
      chk("mid_rst_int", interval, 0);
      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) for (int k = 0; k < 4; k++) prm[k] = 4'($urandom_range(0, 15));
         one_hz_en      = ($urandom % 4) == 0;
         driver_door    = ($urandom % 8) == 0;
         passenger_door = ($urandom % 10) == 0;
         reprogram      = ($urandom % 80) == 0;
         reset          = ($urandom % 600) == 0;
         if (($urandom % 25) == 0) ignition = ~ignition;
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
